// File: rtl/data_ram_arbiter_pkg.sv
// ============================================================================
// data_ram_arbiter_pkg : shared state encodings, master IDs and RAM levels
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic c_ARB_M0 = 1'b0;
  localparam logic c_ARB_M1 = 1'b1;

  localparam logic c_CHIP_ENABLE   = 1'b1;
  localparam logic c_CHIP_DISABLE  = 1'b0;
  localparam logic c_WRITE_ENABLE  = 1'b1;
  localparam logic c_WRITE_DISABLE = 1'b0;

  // On a tie the master that did not win last time takes the grant.
  function automatic logic rr_winner(input logic [1:0] req, input logic last_grant);
    logic id;
    id = c_ARB_M0;
    if (req == 2'b11) begin
      id = ~last_grant;
    end else if (req[1]) begin
      id = c_ARB_M1;
    end
    return id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_arbiter_if.sv
// ============================================================================
// data_ram_arbiter_if : one master's request/acknowledge bus to the arbiter
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface data_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   sel;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );

endinterface

`default_nettype wire

// File: rtl/data_ram_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational two-way round-robin picker
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_pick2
  import data_ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = rr_winner(i_req, i_last_grant);
  end

endmodule

`default_nettype wire

// File: rtl/data_ram_arbiter.sv
// ============================================================================
// data_ram_arbiter : two-master round-robin access to a single-port data RAM
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_arbiter_if.slave   m0_bus,
  data_ram_arbiter_if.slave   m1_bus,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t          r_state;
  logic                r_last_grant;
  logic                r_grant_id;
  logic                r_ce;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_data;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_grant_valid;
  logic                w_grant_id;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [SEL_W-1:0]    w_win_sel;
  logic [DATA_W-1:0]   w_win_wdata;

  rr_pick2 u_pick (
    .i_req         ({m1_bus.req, m0_bus.req}),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_comb begin
    w_win_we    = m0_bus.we;
    w_win_addr  = m0_bus.addr;
    w_win_sel   = m0_bus.sel;
    w_win_wdata = m0_bus.wdata;
    if (w_grant_id == c_ARB_M1) begin
      w_win_we    = m1_bus.we;
      w_win_addr  = m1_bus.addr;
      w_win_sel   = m1_bus.sel;
      w_win_wdata = m1_bus.wdata;
    end
  end

  // Request fields are sampled only at the grant edge; ce/we qualify the held address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= c_ARB_M1;
      r_grant_id   <= c_ARB_M0;
      r_ce         <= c_CHIP_DISABLE;
      r_we         <= c_WRITE_DISABLE;
      r_addr       <= '0;
      r_sel        <= '0;
      r_data       <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_grant_valid) begin
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_ce         <= c_CHIP_ENABLE;
            r_we         <= w_win_we;
            r_addr       <= w_win_addr;
            r_sel        <= w_win_sel;
            r_data       <= w_win_wdata;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_ce <= c_CHIP_DISABLE;
          r_we <= c_WRITE_DISABLE;
          if (r_grant_id == c_ARB_M1) begin
            r_ack1 <= 1'b1;
            if (r_we != c_WRITE_ENABLE) begin
              r_rdata1 <= ram_data_i;
            end
          end else begin
            r_ack0 <= 1'b1;
            if (r_we != c_WRITE_ENABLE) begin
              r_rdata0 <= ram_data_i;
            end
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ce    <= c_CHIP_DISABLE;
          r_we    <= c_WRITE_DISABLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_ce_o     = r_ce;
  assign ram_we_o     = r_we;
  assign ram_addr_o   = r_addr;
  assign ram_sel_o    = r_sel;
  assign ram_data_o   = r_data;
  assign m0_bus.ack   = r_ack0;
  assign m1_bus.ack   = r_ack1;
  assign m0_bus.rdata = r_rdata0;
  assign m1_bus.rdata = r_rdata1;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
// ============================================================================
// tb_data_ram_arbiter : directed scoreboard bench for data_ram_arbiter
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  data_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_bus     (m0_bus),
    .m1_bus     (m1_bus),
    .ram_ce_o   (ram_ce),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_sel_o  (ram_sel),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata),
    .busy_o     (busy)
  );

  // Word-addressed RAM with byte enables, read path combinational while ce=1
  logic [31:0] mem    [0:255] = '{default: '0};
  logic [31:0] shadow [0:255] = '{default: '0};

  assign ram_rdata = ram_ce ? mem[ram_addr[9:2]] : '0;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] q_exp0 [$];
  logic [31:0] q_exp1 [$];
  logic [31:0] last_exp_rd [2] = '{32'h0, 32'h0};
  int          q_order   [$];
  int unsigned q_ack_cyc [$];
  int          ack_cnt0 = 0;
  int          ack_cnt1 = 0;
  logic        prev_ack = 1'b0;

  always @(negedge clk) begin
    if (m0_bus.ack || m1_bus.ack) begin
      check("no_back_to_back_ack", prev_ack, 1'b0);
      check("one_ack_at_a_time", m0_bus.ack & m1_bus.ack, 1'b0);
      q_order.push_back(m1_bus.ack ? 1 : 0);
      q_ack_cyc.push_back(cyc);
    end
    if (m0_bus.ack) begin
      ack_cnt0++;
      check("m0_ack_expected", q_exp0.size() != 0, 1'b1);
      if (q_exp0.size() != 0) check("m0_rdata", m0_bus.rdata, q_exp0.pop_front());
    end
    if (m1_bus.ack) begin
      ack_cnt1++;
      check("m1_ack_expected", q_exp1.size() != 0, 1'b1);
      if (q_exp1.size() != 0) check("m1_rdata", m1_bus.rdata, q_exp1.pop_front());
    end
    prev_ack = m0_bus.ack | m1_bus.ack;
  end

  // Caller is at posedge+1; pushes the expected rdata, holds req until ack, drops it next cycle.
  task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata, input int exp_lat);
    logic [31:0] exp_rd;
    int          lat = 0;
    bit          got = 0;
    int          idx;
    idx = int'(addr[9:2]);
    if (we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
      exp_rd = last_exp_rd[m];
    end else begin
      exp_rd         = shadow[idx];
      last_exp_rd[m] = exp_rd;
    end
    if (m == 0) begin
      q_exp0.push_back(exp_rd);
      m0_bus.we = we; m0_bus.addr = addr; m0_bus.sel = sel; m0_bus.wdata = wdata; m0_bus.req = 1'b1;
    end else begin
      q_exp1.push_back(exp_rd);
      m1_bus.we = we; m1_bus.addr = addr; m1_bus.sel = sel; m1_bus.wdata = wdata; m1_bus.req = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_bus.ack : m1_bus.ack) begin
        got = 1;
        break;
      end
      lat++;
    end
    check($sformatf("m%0d_ack_seen", m), got, 1'b1);
    if (exp_lat >= 0) check($sformatf("m%0d_latency", m), lat, exp_lat);
    @(posedge clk); #1;
    if (m == 0) m0_bus.req = 1'b0; else m1_bus.req = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ce"},     ram_ce,       1'b0);
    check({pfx, "_we"},     ram_we,       1'b0);
    check({pfx, "_addr"},   ram_addr,     32'h0);
    check({pfx, "_sel"},    ram_sel,      4'h0);
    check({pfx, "_wdata"},  ram_wdata,    32'h0);
    check({pfx, "_ack0"},   m0_bus.ack,   1'b0);
    check({pfx, "_ack1"},   m1_bus.ack,   1'b0);
    check({pfx, "_rdata0"}, m0_bus.rdata, 32'h0);
    check({pfx, "_rdata1"}, m1_bus.rdata, 32'h0);
    check({pfx, "_busy"},   busy,         1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    m0_bus.req = 0; m0_bus.we = 0; m0_bus.addr = '0; m0_bus.sel = '0; m0_bus.wdata = '0;
    m1_bus.req = 0; m1_bus.we = 0; m1_bus.addr = '0; m1_bus.sel = '0; m1_bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Both masters request from reset: strict alternation starting with m0
    q_order.delete(); q_ack_cyc.delete();
    fork
      begin
        do_access(0, 1'b1, 32'h40, 4'hF, 32'hA0A0_0001, -1);
        do_access(0, 1'b0, 32'h40, 4'hF, 32'h0,         -1);
        do_access(0, 1'b1, 32'h44, 4'hF, 32'hA0A0_0002, -1);
        do_access(0, 1'b0, 32'h44, 4'hF, 32'h0,         -1);
      end
      begin
        do_access(1, 1'b1, 32'h80, 4'hF, 32'hB1B1_0001, -1);
        do_access(1, 1'b0, 32'h80, 4'hF, 32'h0,         -1);
        do_access(1, 1'b1, 32'h84, 4'hF, 32'hB1B1_0002, -1);
        do_access(1, 1'b0, 32'h84, 4'hF, 32'h0,         -1);
      end
    join
    check("contention_ack_count", q_order.size(), 8);
    for (int i = 0; i < 8 && i < q_order.size(); i++)
      check($sformatf("grant_order_%0d", i), q_order[i], i % 2);
    for (int i = 1; i < 8 && i < q_ack_cyc.size(); i++)
      check($sformatf("ack_spacing_%0d", i), q_ack_cyc[i] - q_ack_cyc[i-1], 3);

    // Single master write then read
    a1 = ack_cnt1;
    do_access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 2);
    do_access(0, 1'b0, 32'h10, 4'hF, 32'h0,         2);
    check("t1_m0_rdata_held", m0_bus.rdata, 32'hDEAD_BEEF);
    check("t1_no_m1_ack", ack_cnt1 - a1, 0);

    // Partial byte write over existing contents
    do_access(1, 1'b1, 32'h20, 4'hF,    32'h1122_3344, 2);
    do_access(1, 1'b1, 32'h20, 4'b0001, 32'h0000_00AA, 2);
    do_access(1, 1'b0, 32'h20, 4'hF,    32'h0,         2);
    check("byte_m1_rdata", m1_bus.rdata, 32'h1122_33AA);

    // m1 pulses req only while the arbiter is busy with m0
    a1 = ack_cnt1;
    fork
      do_access(0, 1'b0, 32'h10, 4'hF, 32'h0, 2);
      begin
        @(posedge clk); #1;
        m1_bus.we = 1'b1; m1_bus.addr = 32'h20; m1_bus.sel = 4'hF; m1_bus.wdata = 32'hBAD0_BAD0;
        m1_bus.req = 1'b1;
        @(posedge clk); #1;
        m1_bus.req = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("withdraw_before_grant_no_ack", ack_cnt1 - a1, 0);

    // m1 drops req right after its grant: access still completes once
    a1 = ack_cnt1;
    last_exp_rd[1] = shadow[8];
    q_exp1.push_back(shadow[8]);
    m1_bus.we = 1'b0; m1_bus.addr = 32'h20; m1_bus.sel = 4'hF; m1_bus.req = 1'b1;
    @(posedge clk); #1;
    m1_bus.req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("withdraw_after_grant_one_ack", ack_cnt1 - a1, 1);

    // Reset during the ACCESS cycle of a write must cancel it
    m0_bus.we = 1'b1; m0_bus.addr = 32'h30; m0_bus.sel = 4'hF; m0_bus.wdata = 32'h55;
    m0_bus.req = 1'b1;
    @(posedge clk); #2;
    check("pre_reset_ce", ram_ce, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_access_reset");
    m0_bus.req = 1'b0;
    last_exp_rd[0] = 32'h0;
    last_exp_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    q_order.delete(); q_ack_cyc.delete();
    fork
      do_access(0, 1'b0, 32'h30, 4'hF, 32'h0, 2);
      do_access(1, 1'b0, 32'h84, 4'hF, 32'h0, -1);
    join
    check("post_reset_tie_count", q_order.size(), 2);
    if (q_order.size() >= 2) begin
      check("post_reset_first_grant", q_order[0], 0);
      check("post_reset_second_grant", q_order[1], 1);
    end
    check("post_reset_addr30_data", m0_bus.rdata, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q_exp0.size() + q_exp1.size(), 0);
    check("idle_at_end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
